// File: rtl/vm_pkg.sv
// Types and constants shared by the coin front end and vending_machine.
package vm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    EMIT,
    REJECT,
    WAIT_RELEASE
  } state_e;

  localparam int unsigned C5  = 0;
  localparam int unsigned C10 = 1;
  localparam int unsigned C20 = 2;
  localparam int unsigned C50 = 3;

  localparam int unsigned VAL_5  = 5;
  localparam int unsigned VAL_10 = 10;
  localparam int unsigned VAL_20 = 20;
  localparam int unsigned VAL_50 = 50;

  function automatic int unsigned coin_value(input int unsigned idx);
    case (idx)
      C5:      return VAL_5;
      C10:     return VAL_10;
      C20:     return VAL_20;
      C50:     return VAL_50;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/coin_acceptor_sync2.sv
// Two-flop synchronizer for a vector of independent asynchronous lines.
module sync2 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/coin_acceptor.sv
// Debounces and classifies raw coin sensors into single-cycle accept/reject
// pulses, with saturating diagnostic counters.
module coin_acceptor
  import vm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned RELEASE_CYCLES  = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw_5,
  input  logic             raw_10,
  input  logic             raw_20,
  input  logic             raw_50,
  input  logic             inhibit,
  output logic             coin_5,
  output logic             coin_10,
  output logic             coin_20,
  output logic             coin_50,
  output logic             coin_reject,
  output logic             busy,
  output logic [CNT_W-1:0] accept_count,
  output logic [CNT_W-1:0] reject_count
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned RW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] REL_LAST = RW'(RELEASE_CYCLES - 1);

  logic [3:0]       raw_w;
  logic [3:0]       s;
  state_e           state_q;
  logic [3:0]       pat_q;
  logic [DW-1:0]    cnt_q;
  logic [RW-1:0]    rel_q;
  logic [3:0]       coin_q;
  logic             reject_q;
  logic             busy_q;
  logic [CNT_W-1:0] acc_q;
  logic [CNT_W-1:0] rej_q;

  always_comb begin
    raw_w      = '0;
    raw_w[C5]  = raw_5;
    raw_w[C10] = raw_10;
    raw_w[C20] = raw_20;
    raw_w[C50] = raw_50;
  end

  sync2 #(.WIDTH(4)) u_sync (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (raw_w),
    .q_o    (s)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      pat_q    <= '0;
      cnt_q    <= '0;
      rel_q    <= '0;
      coin_q   <= '0;
      reject_q <= 1'b0;
      busy_q   <= 1'b0;
      acc_q    <= '0;
      rej_q    <= '0;
    end else begin
      coin_q   <= '0;
      reject_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (s != '0) begin
            pat_q   <= s;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (s != pat_q) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_q != DEB_LAST) begin
            cnt_q <= cnt_q + 1'b1;
          end else if ($onehot(pat_q) && !inhibit) begin
            // Pulse registered on entry so it is high for exactly the EMIT cycle
            coin_q  <= pat_q;
            state_q <= EMIT;
          end else begin
            reject_q <= 1'b1;
            state_q  <= REJECT;
          end
        end
        EMIT: begin
          if (acc_q != '1) acc_q <= acc_q + 1'b1;
          rel_q   <= '0;
          state_q <= WAIT_RELEASE;
        end
        REJECT: begin
          if (rej_q != '1) rej_q <= rej_q + 1'b1;
          rel_q   <= '0;
          state_q <= WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (s != '0) begin
            rel_q <= '0;
          end else if (rel_q == REL_LAST) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            rel_q <= rel_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign coin_5       = coin_q[C5];
  assign coin_10      = coin_q[C10];
  assign coin_20      = coin_q[C20];
  assign coin_50      = coin_q[C50];
  assign coin_reject  = reject_q;
  assign busy         = busy_q;
  assign accept_count = acc_q;
  assign reject_count = rej_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Randomized bench for coin_acceptor against a run-length reference model.
module tb_coin_acceptor;

  localparam int unsigned DEB = 4;
  localparam int unsigned REL = 4;

  logic       clk;
  logic       reset;
  logic [3:0] raw;
  logic       inhibit;

  logic       coin_5, coin_10, coin_20, coin_50, coin_reject, busy;
  logic [7:0] accept_count, reject_count;
  logic       s_coin_5, s_coin_10, s_coin_20, s_coin_50, s_coin_reject, s_busy;
  logic [1:0] s_accept_count, s_reject_count;

  coin_acceptor #(.DEBOUNCE_CYCLES(DEB), .RELEASE_CYCLES(REL), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .raw_5(raw[0]), .raw_10(raw[1]), .raw_20(raw[2]), .raw_50(raw[3]),
    .inhibit(inhibit),
    .coin_5(coin_5), .coin_10(coin_10), .coin_20(coin_20), .coin_50(coin_50),
    .coin_reject(coin_reject), .busy(busy),
    .accept_count(accept_count), .reject_count(reject_count)
  );

  coin_acceptor #(.DEBOUNCE_CYCLES(DEB), .RELEASE_CYCLES(REL), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset),
    .raw_5(raw[0]), .raw_10(raw[1]), .raw_20(raw[2]), .raw_50(raw[3]),
    .inhibit(inhibit),
    .coin_5(s_coin_5), .coin_10(s_coin_10), .coin_20(s_coin_20), .coin_50(s_coin_50),
    .coin_reject(s_coin_reject), .busy(s_busy),
    .accept_count(s_accept_count), .reject_count(s_reject_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit          chk_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: raw lines delayed two edges, then a stable-run / clear-run tracker.
  logic [3:0]  h1 = '0, h2 = '0, s_m = '0, pat_m = '0;
  int unsigned mode = 0;   // 0 armed, 1 tracking a pattern, 2 pulse cycle, 3 waiting for clear
  int unsigned run = 0, zeros = 0, kind = 0, acc = 0, rej = 0;
  logic [4:0]  exp_pulse = '0;
  bit          exp_busy = 1'b0;

  always @(posedge clk) begin
    s_m = h2;
    if (!reset) begin
      h1 = '0; h2 = '0; mode = 0; acc = 0; rej = 0;
      exp_pulse = '0; exp_busy = 1'b0;
    end else begin
      h2 = h1;
      h1 = raw;
      exp_pulse = '0;
      case (mode)
        0: if (s_m != 0) begin pat_m = s_m; run = 1; mode = 1; end
        1: begin
          if (s_m != pat_m) mode = 0;
          else begin
            run++;
            if (run == DEB + 1) begin
              if ($onehot(pat_m) && !inhibit) begin exp_pulse = {1'b0, pat_m}; kind = 1; end
              else begin exp_pulse = 5'b10000; kind = 2; end
              mode = 2;
            end
          end
        end
        2: begin
          if (kind == 1) acc++; else rej++;
          zeros = 0;
          mode = 3;
        end
        default: begin
          if (s_m == 0) zeros++; else zeros = 0;
          if (zeros == REL) mode = 0;
        end
      endcase
      exp_busy = (mode != 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pulses", {27'd0, coin_reject, coin_50, coin_20, coin_10, coin_5}, {27'd0, exp_pulse});
      check("busy", {31'd0, busy}, {31'd0, exp_busy});
      check("accept_count", {24'd0, accept_count}, (acc > 255) ? 255 : acc);
      check("reject_count", {24'd0, reject_count}, (rej > 255) ? 255 : rej);
      check("sat_pulses", {26'd0, s_busy, s_coin_reject, s_coin_50, s_coin_20, s_coin_10, s_coin_5},
            {26'd0, exp_busy, exp_pulse});
      check("sat_accept_count", {30'd0, s_accept_count}, (acc > 3) ? 3 : acc);
      check("sat_reject_count", {30'd0, s_reject_count}, (rej > 3) ? 3 : rej);
    end
  end

  task automatic drive(input logic [3:0] r, input logic inh, input int unsigned n);
    raw     = r;
    inhibit = inh;
    repeat (n) @(negedge clk);
    #2;
  endtask

  initial begin
    logic [3:0] r;
    reset   = 1'b0;
    raw     = '0;
    inhibit = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;

    drive(4'b0000, 0, 5);
    drive(4'b0010, 0, 20);             // clean 10-unit coin
    drive(4'b0000, 0, 10);
    drive(4'b0001, 0, 2);              // bounce on the 5-unit line
    drive(4'b0000, 0, 2);
    drive(4'b0001, 0, 12);
    drive(4'b0000, 0, 10);
    drive(4'b1100, 0, 10);             // two sensors together
    drive(4'b0000, 0, 10);
    drive(4'b1000, 1, 10);             // inhibited coin
    drive(4'b0000, 0, 10);
    drive(4'b1000, 0, 10);
    drive(4'b0000, 0, 10);
    drive(4'b0001, 0, 50);             // held, brief release, re-assert
    drive(4'b0000, 0, 2);
    drive(4'b0001, 0, 20);
    drive(4'b0000, 0, 10);
    drive(4'b0010, 0, 4);              // reset during debounce, line stays high
    reset = 1'b0;
    drive(4'b0010, 0, 2);
    reset = 1'b1;
    drive(4'b0010, 0, 12);
    drive(4'b0000, 0, 10);
    for (int i = 0; i < 5; i++) begin  // enough coins to saturate the narrow counter
      r = 4'b0001 << $urandom_range(0, 3);
      drive(r, 0, 8);
      drive(4'b0000, 0, 6);
    end

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    r = '0;
        2, 3:    r = 4'($urandom_range(0, 15));
        default: r = 4'b0001 << $urandom_range(0, 3);
      endcase
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b0;
        drive(r, 0, $urandom_range(1, 3));
        reset = 1'b1;
      end
      drive(r, ($urandom_range(0, 7) == 0), $urandom_range(1, 12));
    end
    drive(4'b0000, 0, 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
